// File: rtl/mem_wr_arb.sv
// Round-robin write arbiter/sequencer for the shared memory register block.
// A requester holds req/req_data until its one-cycle ack; data is captured at grant.
module mem_wr_arb #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 6,
    parameter int TIMEOUT = 8,
    parameter int CNT_W   = 8,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic                      in_clk,
    input  logic                      in_rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        ack,
    output logic [IDX_W-1:0]          grant_idx,
    output logic                      busy,
    output logic                      mem_wrt_en,
    output logic [DATA_W-1:0]         mem_data,
    input  logic                      mem_wrt_rd,
    output logic                      timeout_err,
    output logic [CNT_W-1:0]          wr_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_e               state_q, state_d;
    logic [7:0]           timer_q, timer_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     grant_q, grant_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic                 busy_q, busy_d;
    logic                 en_q, en_d;
    logic                 terr_q, terr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic                 win_found;
    logic [IDX_W-1:0]     win_idx;
    logic [IDX_W-1:0]     cand;
    logic                 wait_ok;
    logic                 wait_err;

    // Search starts one past the last winner, so that winner ends up last in line.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            ptr_q   <= IDX_W'(NUM_REQ - 1);
            grant_q <= '0;
            data_q  <= '0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
            en_q    <= 1'b0;
            terr_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            en_q    <= en_d;
            terr_q  <= terr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        wait_ok  = 1'b0;
        wait_err = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (win_found) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A ready pulse on the final timer cycle still counts as success.
                if (mem_wrt_rd) begin
                    wait_ok = 1'b1;
                    state_d = S_DONE;
                end else if (timer_q == TIMER_LAST) begin
                    wait_err = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        grant_d = grant_q;
        data_d  = data_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        ack_d   = '0;
        terr_d  = 1'b0;
        en_d    = (state_d == S_ISSUE);
        busy_d  = (state_d != S_IDLE);
        if (state_q == S_IDLE && win_found) begin
            grant_d = win_idx;
            data_d  = req_data[win_idx*DATA_W +: DATA_W];
        end
        if (wait_ok || wait_err) begin
            ack_d[grant_q] = 1'b1;
        end
        if (wait_ok) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (wait_err) begin
            terr_d = 1'b1;
        end
        if (state_q == S_DONE) begin
            ptr_d = grant_q;
        end
    end

    assign ack         = ack_q;
    assign grant_idx   = grant_q;
    assign busy        = busy_q;
    assign mem_wrt_en  = en_q;
    assign mem_data    = data_q;
    assign timeout_err = terr_q;
    assign wr_count    = cnt_q;

endmodule

// File: tb/tb_mem_wr_arb.sv
// Directed bench for mem_wr_arb: latency, round-robin order, timeout, reset abort, counter wrap.
module tb_mem_wr_arb;

    logic        in_clk = 1'b0;
    logic        in_rst = 1'b1;
    logic [3:0]  req = '0;
    logic [23:0] req_data = '0;
    logic        rd_model = 1'b0;
    logic        rd_extra = 1'b0;
    logic        ready_en = 1'b1;
    logic        mem_wrt_rd;
    logic        en_s;

    logic [3:0]  ack, ack_w;
    logic [1:0]  grant_idx, grant_idx_w;
    logic        busy, busy_w;
    logic        mem_wrt_en, mem_wrt_en_w;
    logic [5:0]  mem_data, mem_data_w;
    logic        timeout_err, timeout_err_w;
    logic [7:0]  wr_count;
    logic [2:0]  wr_count_w;

    int          checks = 0;
    int          failures = 0;
    logic [5:0]  exp_q[$];
    int          ack_cnt[4];

    assign mem_wrt_rd = rd_model | rd_extra;

    always #5 in_clk = ~in_clk;

    mem_wr_arb #(.NUM_REQ(4), .DATA_W(6), .TIMEOUT(8), .CNT_W(8)) dut (
        .in_clk(in_clk), .in_rst(in_rst), .req(req), .req_data(req_data),
        .ack(ack), .grant_idx(grant_idx), .busy(busy), .mem_wrt_en(mem_wrt_en),
        .mem_data(mem_data), .mem_wrt_rd(mem_wrt_rd), .timeout_err(timeout_err),
        .wr_count(wr_count)
    );

    mem_wr_arb #(.NUM_REQ(4), .DATA_W(6), .TIMEOUT(8), .CNT_W(3)) dut_w (
        .in_clk(in_clk), .in_rst(in_rst), .req(req), .req_data(req_data),
        .ack(ack_w), .grant_idx(grant_idx_w), .busy(busy_w), .mem_wrt_en(mem_wrt_en_w),
        .mem_data(mem_data_w), .mem_wrt_rd(mem_wrt_rd), .timeout_err(timeout_err_w),
        .wr_count(wr_count_w)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Memory register model: ready pulse one cycle after the strobe.
    always @(posedge in_clk) begin
        en_s = mem_wrt_en;
        #1 rd_model = en_s & ready_en;
    end

    // Scoreboard: every strobe must carry the next expected data word.
    always @(negedge in_clk) begin
        if (!in_rst) begin
            if (mem_wrt_en) begin
                if (exp_q.size() == 0) chk("unexpected_strobe", 32'd1, 32'd0);
                else chk("strobe_data", 32'(mem_data), 32'(exp_q.pop_front()));
            end
            for (int i = 0; i < 4; i++) ack_cnt[i] += int'(ack[i]);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge in_clk);
    endtask

    task automatic do_reset();
        in_rst   = 1'b1;
        req      = '0;
        rd_extra = 1'b0;
        ready_en = 1'b1;
        for (int i = 0; i < 4; i++) ack_cnt[i] = 0;
        tick(2);
        in_rst = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ack"}, 32'(ack), 32'h0);
        chk({tag, "_grant"}, 32'(grant_idx), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_en"}, 32'(mem_wrt_en), 32'h0);
        chk({tag, "_data"}, 32'(mem_data), 32'h0);
        chk({tag, "_terr"}, 32'(timeout_err), 32'h0);
        chk({tag, "_count"}, 32'(wr_count), 32'h0);
    endtask

    task automatic wait_ack(input string tag, input int idx);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 24 && !seen; c++) begin
            tick(1);
            if (ack != 4'b0) seen = 1'b1;
        end
        if (!seen) chk({tag, "_ack_timeout"}, 32'd0, 32'd1);
        else chk({tag, "_ack_idx"}, 32'(ack), 32'(1 << idx));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // 1: single write with exact latency and data capture at grant
        do_reset();
        check_reset_outputs("rst");
        exp_q.push_back(6'h2A);
        req_data[5:0] = 6'h2A;
        req = 4'b0001;
        tick(1);
        chk("t1_strobe", 32'(mem_wrt_en), 32'd1);
        chk("t1_data", 32'(mem_data), 32'h2A);
        chk("t1_grant", 32'(grant_idx), 32'd0);
        chk("t1_busy", 32'(busy), 32'd1);
        req_data[5:0] = 6'h3F;
        tick(1);
        chk("t1_strobe_once", 32'(mem_wrt_en), 32'd0);
        chk("t1_data_held", 32'(mem_data), 32'h2A);
        chk("t1_no_early_ack", 32'(ack), 32'h0);
        tick(1);
        chk("t1_ack", 32'(ack), 32'b0001);
        chk("t1_count", 32'(wr_count), 32'd1);
        chk("t1_terr", 32'(timeout_err), 32'd0);
        req = 4'b0000;
        tick(1);
        chk("t1_ack_pulse", 32'(ack), 32'h0);
        chk("t1_idle", 32'(busy), 32'd0);
        rd_extra = 1'b1;
        tick(1);
        rd_extra = 1'b0;
        tick(2);
        chk("t1_stray_ready_busy", 32'(busy), 32'd0);
        chk("t1_stray_ready_count", 32'(wr_count), 32'd1);
        chk("t1_mem_data_kept", 32'(mem_data), 32'h3F & 32'h2A);
        chk("t1_ack_total", 32'(ack_cnt[0]), 32'd1);

        // 2: simultaneous requests 1 and 2
        do_reset();
        req_data[11:6]  = 6'h11;
        req_data[17:12] = 6'h22;
        exp_q.push_back(6'h11);
        exp_q.push_back(6'h22);
        req = 4'b0110;
        wait_ack("t2_first", 1);
        chk("t2_grant_first", 32'(grant_idx), 32'd1);
        req[1] = 1'b0;
        wait_ack("t2_second", 2);
        chk("t2_grant_second", 32'(grant_idx), 32'd2);
        req = 4'b0000;
        tick(1);
        chk("t2_count", 32'(wr_count), 32'd2);

        // 3: fairness with all four requesting
        do_reset();
        for (int i = 0; i < 4; i++) req_data[i*6 +: 6] = 6'(6'h30 + i);
        for (int k = 0; k < 16; k++) exp_q.push_back(6'(6'h30 + (k % 4)));
        req = 4'b1111;
        for (int k = 0; k < 16; k++) begin
            wait_ack("t3_rr", k % 4);
            if (k == 15) req = 4'b0000;
        end
        tick(1);
        chk("t3_count", 32'(wr_count), 32'd16);
        for (int i = 0; i < 4; i++) chk("t3_acks_per_req", 32'(ack_cnt[i]), 32'd4);

        // 4: timeout on requester 3
        do_reset();
        ready_en = 1'b0;
        req_data[23:18] = 6'h15;
        exp_q.push_back(6'h15);
        req = 4'b1000;
        tick(1);
        chk("t4_strobe", 32'(mem_wrt_en), 32'd1);
        for (int i = 0; i < 8; i++) begin
            tick(1);
            chk("t4_waiting", 32'({ack, busy, mem_wrt_en, timeout_err}), 32'b0000_1_0_0);
        end
        tick(1);
        chk("t4_ack", 32'(ack), 32'b1000);
        chk("t4_terr", 32'(timeout_err), 32'd1);
        chk("t4_count", 32'(wr_count), 32'd0);
        req = 4'b0000;
        tick(1);
        chk("t4_busy_drop", 32'(busy), 32'd0);
        chk("t4_terr_pulse", 32'(timeout_err), 32'd0);

        // 5: reset during WAIT of requester 2, then requester 0 first
        do_reset();
        ready_en = 1'b0;
        req_data[17:12] = 6'h07;
        exp_q.push_back(6'h07);
        req = 4'b0100;
        tick(2);
        chk("t5_in_wait", 32'({busy, mem_wrt_en, grant_idx}), 32'b1_0_10);
        in_rst = 1'b1;
        tick(1);
        check_reset_outputs("t5_abort");
        in_rst   = 1'b0;
        ready_en = 1'b1;
        req_data[5:0] = 6'h09;
        exp_q.push_back(6'h09);
        req = 4'b0101;
        wait_ack("t5_after", 0);
        chk("t5_grant", 32'(grant_idx), 32'd0);
        chk("t5_no_abort_ack", 32'(ack_cnt[2]), 32'd0);
        req = 4'b0000;
        tick(1);

        // 6: 3-bit counter wraps on the eighth write
        do_reset();
        req_data[5:0] = 6'h05;
        for (int k = 0; k < 9; k++) exp_q.push_back(6'h05);
        req = 4'b0001;
        for (int k = 1; k <= 9; k++) begin
            wait_ack("t6_write", 0);
            chk("t6_wrap_count", 32'(wr_count_w), 32'(k % 8));
            if (k == 9) req = 4'b0000;
        end
        tick(1);
        chk("t6_wide_count", 32'(wr_count), 32'd9);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
